rw_arb: RTL

- Parametrised N-channel access arbiter, successor to the two-channel write-priority read/write controller.
- Sits between request sources (sampler, host interface, readout engines) and a single shared memory/bus port.
- Latches pulse requests as pending, grants one channel at a time (one-hot plus index) in fixed or round-robin order, and releases the grant on a done handshake.
- Optional preemption by level-type channels and an optional grant timeout.

---
 rtl/rw_arb.sv | 82 ++++++++
 1 files changed

// File: rtl/rw_arb.sv
// rw_arb: N-channel pulse/level request arbiter with fixed or round-robin priority, preemption and grant timeout
module rw_arb #(
    parameter int NCH = 4,
    parameter int IDW = 2,
    parameter logic [NCH-1:0] LVL_MASK = NCH'(1),
    parameter int MODE = 0,
    parameter int PREEMPT = 1,
    parameter int TMO = 0,
    parameter int TW = 8
) (
    input  logic           clk,
    input  logic           nrst,
    input  logic [NCH-1:0] req,
    input  logic [NCH-1:0] done,
    output logic [NCH-1:0] gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           busy,
    output logic [NCH-1:0] ovf,
    output logic           tmo
);
    typedef enum logic {IDLE, GRANT} state_t;
    localparam logic [TW-1:0] TLAST = TW'(TMO == 0 ? 0 : TMO - 1);
    state_t st;
    logic [NCH-1:0] pend, blk, lcand, pcand, xm, clr, win_oh;
    logic [IDW-1:0] ptr, win;
    logic [TW-1:0] cnt;
    logic cur_lvl, pre, to, rel, ng;
    function automatic logic [IDW-1:0] pick(input logic [NCH-1:0] c, input logic [IDW-1:0] p);
        logic [IDW-1:0] r;
        logic [NCH-1:0] s;
        int idx;
        r = '0;
        for (int k = NCH; k >= 1; k--) begin
            idx = ((MODE != 0) ? int'(p) + k : k - 1) % NCH;
            s = c >> idx;
            if (s[0]) r = IDW'(idx);
        end
        return r;
    endfunction
    assign busy = |gnt;
    always_comb begin
        cur_lvl = |(gnt & LVL_MASK);
        lcand = req & LVL_MASK & ~blk;
        pcand = pend & ~LVL_MASK;
        pre = (PREEMPT != 0) && (st == GRANT) && !cur_lvl && (|lcand);
        to = (TMO != 0) && (st == GRANT) && (cnt == TLAST);
        rel = (st == GRANT) && (pre || to || (cur_lvl ? !(|(req & gnt)) : |(done & gnt)));
        xm = (to && cur_lvl) ? gnt : '0;
        win = (|(lcand & ~xm)) ? pick(lcand & ~xm, ptr) : pick(pcand, ptr);
        ng = ((st == IDLE) || rel) && (|((lcand & ~xm) | pcand));
        win_oh = NCH'(1) << win;
        clr = ng ? win_oh : '0;
    end
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            st <= IDLE;
            gnt <= '0;
            gnt_id <= '0;
            ptr <= IDW'(NCH - 1);
            cnt <= '0;
            pend <= '0;
            blk <= '0;
            ovf <= '0;
            tmo <= 1'b0;
        end else begin
            pend <= ((pend & ~clr) | req | ((pre && !(|(done & gnt))) ? gnt : '0)) & ~LVL_MASK;
            blk <= (blk & req) | ((to && !pre && cur_lvl) ? gnt : '0);
            ovf <= req & pend & ~clr & ~LVL_MASK;
            tmo <= to && !pre;
            cnt <= (ng || rel || (st == IDLE)) ? '0 : cnt + 1'b1;
            if (ng) begin
                st <= GRANT;
                gnt <= win_oh;
                gnt_id <= win;
                ptr <= win;
            end else if (rel) begin
                st <= IDLE;
                gnt <= '0;
            end
        end
    end
endmodule
